// File: rtl/calc_operand_entry_pkg.sv
// Shared types for the calculator keypad operand entry block:
// key codes, ALU operation encodings, FSM states and key classification.
package calc_operand_entry_pkg;

  localparam int NDIGITS_DEF = 8;
  localparam int DPW_DEF     = 3;

  localparam logic [4:0] KEY_DP     = 5'd10;
  localparam logic [4:0] KEY_SIGN   = 5'd11;
  localparam logic [4:0] KEY_OP_LO  = 5'd12;
  localparam logic [4:0] KEY_OP_HI  = 5'd16;
  localparam logic [4:0] KEY_EQUALS = 5'd17;
  localparam logic [4:0] KEY_CLEAR  = 5'd18;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_POW = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    K_DIGIT,
    K_DP,
    K_SIGN,
    K_OP,
    K_EQ,
    K_CLR,
    K_BAD
  } key_kind_e;

  function automatic key_kind_e key_kind(input logic [4:0] code);
    key_kind_e k;
    k = K_BAD;
    unique case (1'b1)
      (code <= 5'd9):         k = K_DIGIT;
      (code == KEY_DP):       k = K_DP;
      (code == KEY_SIGN):     k = K_SIGN;
      (code >= KEY_OP_LO &&
       code <= KEY_OP_HI):    k = K_OP;
      (code == KEY_EQUALS):   k = K_EQ;
      (code == KEY_CLEAR):    k = K_CLR;
      default:                k = K_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/calc_operand_entry_if.sv
// Keypad input plus ALU operand/operation handshake bundle.
// master = operand producer, slave = keypad/ALU environment.
interface calc_operand_entry_if #(
  parameter int NDIGITS = 8,
  parameter int DPW     = 3
);
  logic                   key_valid;
  logic [4:0]             key_code;
  logic                   key_ready;
  logic                   sgn0;
  logic                   sgn1;
  logic [4*NDIGITS-1:0]   num0;
  logic [4*NDIGITS-1:0]   num1;
  logic [DPW-1:0]         dp0;
  logic [DPW-1:0]         dp1;
  logic [2:0]             operation;
  logic                   op_valid;
  logic                   op_ready;

  modport master (
    input  key_valid, key_code, op_ready,
    output key_ready, sgn0, sgn1, num0, num1,
    output dp0, dp1, operation, op_valid
  );

  modport slave (
    output key_valid, key_code, op_ready,
    input  key_ready, sgn0, sgn1, num0, num1,
    input  dp0, dp1, operation, op_valid
  );
endinterface

// File: rtl/calc_operand_entry_reg.sv
// One BCD operand register: digit shift-in, significant-digit count,
// decimal-point tracking and sign.
module calc_operand_entry_reg #(
  parameter  int NDIGITS = 8,
  parameter  int DPW     = 3,
  localparam int CNTW    = $clog2(NDIGITS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 digit_en_i,
  input  logic [3:0]           digit_i,
  input  logic                 dp_en_i,
  input  logic                 sgn_en_i,
  output logic [4*NDIGITS-1:0] num_o,
  output logic [DPW-1:0]       dp_o,
  output logic                 sgn_o,
  output logic [CNTW-1:0]      cnt_o,
  output logic                 dp_seen_o
);

  logic [4*NDIGITS-1:0] num_q, num_d;
  logic [DPW-1:0]       dp_q, dp_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;
  logic                 dps_q, dps_d;
  logic                 full;
  logic                 lead_zero;

  assign full      = (cnt_q == CNTW'(NDIGITS));
  assign lead_zero = (cnt_q == '0) && (digit_i == 4'd0) && !dps_q;

  always_comb begin
    num_d = num_q;
    dp_d  = dp_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    dps_d = dps_q;
    if (clr_i) begin
      num_d = '0;
      dp_d  = '0;
      cnt_d = '0;
      sgn_d = 1'b0;
      dps_d = 1'b0;
    end else begin
      if (digit_en_i && !full && !lead_zero) begin
        num_d = {num_q[4*NDIGITS-5:0], digit_i};
        cnt_d = cnt_q + 1'b1;
        if (dps_q) dp_d = dp_q + 1'b1;
      end
      // A point typed first stands for an implicit leading zero.
      if (dp_en_i && !dps_q) begin
        dps_d = 1'b1;
        if (cnt_q == '0) cnt_d = CNTW'(1);
      end
      if (sgn_en_i) sgn_d = ~sgn_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      num_q <= '0;
      dp_q  <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      dps_q <= 1'b0;
    end else begin
      num_q <= num_d;
      dp_q  <= dp_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      dps_q <= dps_d;
    end
  end

  assign num_o     = num_q;
  assign dp_o      = dp_q;
  assign sgn_o     = sgn_q;
  assign cnt_o     = cnt_q;
  assign dp_seen_o = dps_q;

endmodule

// File: rtl/calc_operand_entry.sv
// Keypad-side operand producer: entry FSM, two operand registers,
// valid/ready issue to the ALU and display mirror of the edited operand.
module calc_operand_entry
  import calc_operand_entry_pkg::*;
#(
  parameter  int NDIGITS = NDIGITS_DEF,
  parameter  int DPW     = DPW_DEF,
  localparam int CNTW    = $clog2(NDIGITS + 1)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  calc_operand_entry_if.master bus,
  output logic [4*NDIGITS-1:0] disp_num_o,
  output logic                 disp_sgn_o,
  output logic [DPW-1:0]       disp_dp_o,
  output logic                 key_ignored_o
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   ign_q, ign_d;

  logic dig_en, dp_en, sgn_en;
  logic clr_a, clr_b;
  logic edit_a, key_acc;
  logic ed_full, ed_dps, b_empty;
  op_e  key_op;
  key_kind_e kind;

  logic [4*NDIGITS-1:0] a_num, b_num;
  logic [DPW-1:0]       a_dp, b_dp;
  logic                 a_sgn, b_sgn;
  logic [CNTW-1:0]      a_cnt, b_cnt;
  logic                 a_dps, b_dps;

  assign kind    = key_kind(bus.key_code);
  assign key_acc = bus.key_valid && bus.key_ready;
  assign edit_a  = (state_q == S_A);
  // Op keys 12..16 map to 0..4 via their low three bits minus 4 (mod 8).
  assign key_op  = op_e'(bus.key_code[2:0] - 3'd4);

  assign ed_full = edit_a ? (a_cnt == CNTW'(NDIGITS))
                          : (b_cnt == CNTW'(NDIGITS));
  assign ed_dps  = edit_a ? a_dps : b_dps;
  assign b_empty = (b_cnt == '0) && !b_dps;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ign_d   = 1'b0;
    dig_en  = 1'b0;
    dp_en   = 1'b0;
    sgn_en  = 1'b0;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    unique case (state_q)
      S_A, S_B: begin
        if (key_acc) begin
          unique case (kind)
            K_DIGIT: begin
              dig_en = 1'b1;
              ign_d  = ed_full;
            end
            K_DP: begin
              dp_en = 1'b1;
              ign_d = ed_dps;
            end
            K_SIGN: sgn_en = 1'b1;
            K_OP: begin
              if (edit_a) begin
                op_d    = key_op;
                clr_b   = 1'b1;
                state_d = S_B;
              end else if (b_empty) begin
                op_d = key_op;
              end else begin
                ign_d = 1'b1;
              end
            end
            K_EQ: begin
              if (edit_a) ign_d = 1'b1;
              else state_d = S_ISSUE;
            end
            K_CLR: begin
              clr_a   = 1'b1;
              clr_b   = 1'b1;
              op_d    = OP_ADD;
              state_d = S_A;
            end
            default: ign_d = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        if (bus.op_ready) begin
          clr_a   = 1'b1;
          clr_b   = 1'b1;
          op_d    = OP_ADD;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_A;
      op_q    <= OP_ADD;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ign_q   <= ign_d;
    end
  end

  calc_operand_entry_reg #(.NDIGITS(NDIGITS), .DPW(DPW)) u_opa (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .clr_i      (clr_a),
    .digit_en_i (dig_en && edit_a),
    .digit_i    (bus.key_code[3:0]),
    .dp_en_i    (dp_en && edit_a),
    .sgn_en_i   (sgn_en && edit_a),
    .num_o      (a_num),
    .dp_o       (a_dp),
    .sgn_o      (a_sgn),
    .cnt_o      (a_cnt),
    .dp_seen_o  (a_dps)
  );

  calc_operand_entry_reg #(.NDIGITS(NDIGITS), .DPW(DPW)) u_opb (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .clr_i      (clr_b),
    .digit_en_i (dig_en && !edit_a),
    .digit_i    (bus.key_code[3:0]),
    .dp_en_i    (dp_en && !edit_a),
    .sgn_en_i   (sgn_en && !edit_a),
    .num_o      (b_num),
    .dp_o       (b_dp),
    .sgn_o      (b_sgn),
    .cnt_o      (b_cnt),
    .dp_seen_o  (b_dps)
  );

  assign bus.key_ready = (state_q != S_ISSUE);
  assign bus.op_valid  = (state_q == S_ISSUE);
  assign bus.num0      = a_num;
  assign bus.num1      = b_num;
  assign bus.dp0       = a_dp;
  assign bus.dp1       = b_dp;
  assign bus.sgn0      = a_sgn;
  assign bus.sgn1      = b_sgn;
  assign bus.operation = op_q;

  assign disp_num_o    = edit_a ? a_num : b_num;
  assign disp_sgn_o    = edit_a ? a_sgn : b_sgn;
  assign disp_dp_o     = edit_a ? a_dp : b_dp;
  assign key_ignored_o = ign_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Bench for calc_operand_entry: directed key sequences with literal
// expectations, then randomized keys checked against a decimal model.
module tb_calc_operand_entry;

  logic        clk;
  logic        rst;
  logic [31:0] disp_num;
  logic        disp_sgn;
  logic [2:0]  disp_dp;
  logic        key_ign;

  calc_operand_entry_if #(.NDIGITS(8), .DPW(3)) bus ();

  calc_operand_entry dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .bus           (bus),
    .disp_num_o    (disp_num),
    .disp_sgn_o    (disp_sgn),
    .disp_dp_o     (disp_dp),
    .key_ignored_o (key_ign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    longint val;
    int     cnt;
    bit     dps;
    int     dp;
    bit     sgn;
  } opnd_t;

  opnd_t m[2];
  int    mode;
  int    mop;
  bit    mign;
  bit    live = 1'b0;

  function automatic opnd_t blank();
    opnd_t o;
    o.val = 0; o.cnt = 0; o.dps = 0; o.dp = 0; o.sgn = 0;
    return o;
  endfunction

  function automatic logic [31:0] bcd(input longint v);
    logic [31:0] r;
    longint t;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic clear_all();
    m[0] = blank();
    m[1] = blank();
    mop  = 0;
    mode = 0;
  endtask

  task automatic model_key(input int c);
    int i;
    i = (mode == 0) ? 0 : 1;
    if (c <= 9) begin
      if (m[i].cnt == 8) mign = 1;
      else if (!(m[i].cnt == 0 && c == 0 && !m[i].dps)) begin
        m[i].val = m[i].val * 10 + c;
        m[i].cnt++;
        if (m[i].dps) m[i].dp++;
      end
    end else if (c == 10) begin
      if (m[i].dps) mign = 1;
      else begin
        m[i].dps = 1;
        if (m[i].cnt == 0) m[i].cnt = 1;
      end
    end else if (c == 11) begin
      m[i].sgn = !m[i].sgn;
    end else if (c >= 12 && c <= 16) begin
      if (mode == 0) begin
        mop  = c - 12;
        m[1] = blank();
        mode = 1;
      end else if (m[1].cnt == 0 && !m[1].dps) mop = c - 12;
      else mign = 1;
    end else if (c == 17) begin
      if (mode == 1) mode = 2;
      else mign = 1;
    end else if (c == 18) begin
      clear_all();
    end else begin
      mign = 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mign = 0;
      if (rst) begin
        clear_all();
        live = 1;
      end else if (live) begin
        if (mode == 2) begin
          if (bus.op_ready) clear_all();
        end else if (bus.key_valid) begin
          model_key(int'(bus.key_code));
        end
      end
    end
  end

  initial begin
    opnd_t d;
    forever begin
      @(negedge clk);
      if (live) begin
        d = (mode == 0) ? m[0] : m[1];
        chk("key_ready", 32'(bus.key_ready), 32'(mode != 2));
        chk("op_valid", 32'(bus.op_valid), 32'(mode == 2));
        chk("key_ignored", 32'(key_ign), 32'(mign));
        chk("num0", bus.num0, bcd(m[0].val));
        chk("num1", bus.num1, bcd(m[1].val));
        chk("dp0", 32'(bus.dp0), 32'(m[0].dp));
        chk("dp1", 32'(bus.dp1), 32'(m[1].dp));
        chk("sgn0", 32'(bus.sgn0), 32'(m[0].sgn));
        chk("sgn1", 32'(bus.sgn1), 32'(m[1].sgn));
        chk("operation", 32'(bus.operation), 32'(mop));
        chk("disp_num", disp_num, bcd(d.val));
        chk("disp_sgn", 32'(disp_sgn), 32'(d.sgn));
        chk("disp_dp", 32'(disp_dp), 32'(d.dp));
      end
    end
  end

  task automatic key(input logic [4:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] kc;
    int r;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    bus.op_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_key_ready", 32'(bus.key_ready), 32'd1);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_num0", bus.num0, 32'd0);
    chk("rst_ign", 32'(key_ign), 32'd0);

    // 12.5 + 3 with the ALU always ready
    bus.op_ready = 1'b1;
    key(5'd1); key(5'd2); key(5'd10); key(5'd5);
    key(5'd12); key(5'd3); key(5'd17);
    chk("s1_op_valid", 32'(bus.op_valid), 32'd1);
    chk("s1_num0", bus.num0, 32'h0000_0125);
    chk("s1_model_num0", bcd(m[0].val), 32'h0000_0125);
    chk("s1_dp0", 32'(bus.dp0), 32'd1);
    chk("s1_num1", bus.num1, 32'h0000_0003);
    chk("s1_dp1", 32'(bus.dp1), 32'd0);
    chk("s1_oper", 32'(bus.operation), 32'd0);
    @(posedge clk); #1;
    chk("s1_op_valid_drop", 32'(bus.op_valid), 32'd0);
    chk("s1_cleared", bus.num0, 32'd0);

    for (int i = 1; i <= 9; i++) key(5'(i));
    chk("s2_num0", bus.num0, 32'h1234_5678);
    chk("s2_model_num0", bcd(m[0].val), 32'h1234_5678);
    chk("s2_ign", 32'(key_ign), 32'd1);
    key(5'd18);

    key(5'd0); key(5'd0); key(5'd10); key(5'd0); key(5'd7);
    chk("s3_num0", bus.num0, 32'h0000_0007);
    chk("s3_dp0", 32'(bus.dp0), 32'd2);
    chk("s3_ign0", 32'(key_ign), 32'd0);
    key(5'd10);
    chk("s3_ign_dp", 32'(key_ign), 32'd1);
    @(posedge clk); #1;
    chk("s3_ign_pulse", 32'(key_ign), 32'd0);
    key(5'd18);

    bus.op_ready = 1'b0;
    key(5'd5); key(5'd11); key(5'd14); key(5'd15); key(5'd2);
    chk("s4_sgn0", 32'(bus.sgn0), 32'd1);
    chk("s4_oper", 32'(bus.operation), 32'd3);
    chk("s4_num1", bus.num1, 32'h0000_0002);
    key(5'd17);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'd1;
    for (int i = 0; i < 4; i++) begin
      chk("s5_op_valid", 32'(bus.op_valid), 32'd1);
      chk("s5_key_ready", 32'(bus.key_ready), 32'd0);
      chk("s5_num0", bus.num0, 32'h0000_0005);
      chk("s5_num1", bus.num1, 32'h0000_0002);
      chk("s5_oper", 32'(bus.operation), 32'd3);
      @(posedge clk); #1;
    end
    bus.op_ready = 1'b1;
    @(posedge clk); #1;
    bus.op_ready  = 1'b0;
    bus.key_valid = 1'b0;
    chk("s5_op_valid_drop", 32'(bus.op_valid), 32'd0);
    chk("s5_key_ready", 32'(bus.key_ready), 32'd1);
    chk("s5_num0_clr", bus.num0, 32'd0);
    chk("s5_sgn0_clr", 32'(bus.sgn0), 32'd0);
    chk("s5_oper_clr", 32'(bus.operation), 32'd0);

    key(5'd19);
    chk("bad_key_ign", 32'(key_ign), 32'd1);
    key(5'd17);
    chk("eq_in_a_ign", 32'(key_ign), 32'd1);
    key(5'd3); key(5'd12); key(5'd4); key(5'd13);
    chk("chain_ign", 32'(key_ign), 32'd1);
    chk("chain_oper", 32'(bus.operation), 32'd0);
    key(5'd18);

    key(5'd4); key(5'd12); key(5'd6); key(5'd17);
    chk("s6_op_valid", 32'(bus.op_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s6_op_valid", 32'(bus.op_valid), 32'd0);
    chk("s6_num0", bus.num0, 32'd0);
    chk("s6_num1", bus.num1, 32'd0);
    chk("s6_key_ready", 32'(bus.key_ready), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      kc = 5'($urandom_range(0, 9));
      else if (r < 62) kc = 5'd10;
      else if (r < 67) kc = 5'd11;
      else if (r < 77) kc = 5'($urandom_range(12, 16));
      else if (r < 87) kc = 5'd17;
      else if (r < 89) kc = 5'd18;
      else if (r < 93) kc = 5'($urandom_range(19, 31));
      else             kc = 5'd0;
      bus.key_valid = ($urandom_range(0, 3) != 0);
      bus.key_code  = kc;
      bus.op_ready  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 249) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
